// File: rtl/video_timing.sv
// -----------------------------------------------------------------------------
// video_timing
// Raster timing generator feeding video_controller and the output encoder.
// Walks a pixel/line raster of H_TOTAL x V_TOTAL positions and emits, for the
// position currently on pixel/line, the line/frame strobes, the active-video
// flag and both syncs. Every output is a register, and all flags are computed
// from the next position and registered together with it, so coordinates and
// flags are never skewed relative to each other.
//
// Ports:
//   clk        in   pixel clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   1: advance one position per clock, 0: freeze (stall)
//   pixel      out  [11:0] horizontal position, 0..H_TOTAL-1
//   line       out  [11:0] vertical position, 0..V_TOTAL-1
//   line_end   out  strobe on the last pixel of every line
//   frame_end  out  strobe on the last pixel of the last line
//   halt       out  high while the raster is frozen (downstream CE = ~halt)
//   de         out  active-video flag
//   hsync      out  horizontal sync, active level HS_POL
//   vsync      out  vertical sync, active level VS_POL
//
// Handshake: enable is a plain level, sampled on every rising edge. There is
// no ready path back; halt reports, one register later, that the edge just
// taken did not advance, so every cycle with halt=0 is a fresh position that
// downstream must consume exactly once.
// -----------------------------------------------------------------------------
module video_timing #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [11:0] pixel,
    output logic [11:0] line,
    output logic        line_end,
    output logic        frame_end,
    output logic        halt,
    output logic        de,
    output logic        hsync,
    output logic        vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4096 || H_TOTAL < 1) begin : g_bad_h_total
            $error("video_timing: H_TOTAL must be in 1..4096");
        end
        if (V_TOTAL > 4096 || V_TOTAL < 1) begin : g_bad_v_total
            $error("video_timing: V_TOTAL must be in 1..4096");
        end
    endgenerate

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Region thresholds are 13 bits wide so that a boundary equal to 4096
    // (e.g. zero back porch on a 4096-wide raster) is still representable.
    localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_STOP   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
    localparam logic [12:0] VS_START  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_STOP   = 13'(V_ACTIVE + V_FP + V_SYNC);

    // Run/frozen state. halt is the decoded state register itself.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [11:0] next_pixel;
    logic [11:0] next_line;
    logic        next_line_end;
    logic        next_frame_end;
    logic        next_de;
    logic        next_hsync;
    logic        next_vsync;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FROZEN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_FROZEN;
        if (enable) begin
            next_state = ST_RUN;
        end
    end

    assign halt = (state == ST_FROZEN);

    // ------------------------------------------------- next position + flags
    // Wrap is an explicit compare against the last position, never overflow.
    always_comb begin
        next_pixel = pixel + 12'd1;
        next_line  = line;
        if (pixel == H_LAST) begin
            next_pixel = '0;
            next_line  = (line == V_LAST) ? '0 : line + 12'd1;
        end
    end

    always_comb begin
        next_line_end  = (next_pixel == H_LAST);
        next_frame_end = next_line_end && (next_line == V_LAST);
        next_de        = ({1'b0, next_pixel} < H_ACT_END) &&
                         ({1'b0, next_line}  < V_ACT_END);
        next_hsync     = ~HS_POL;
        if (({1'b0, next_pixel} >= HS_START) && ({1'b0, next_pixel} < HS_STOP)) begin
            next_hsync = HS_POL;
        end
        // next_line only changes when next_pixel wraps to 0, so vsync
        // naturally toggles on line boundaries.
        next_vsync     = ~VS_POL;
        if (({1'b0, next_line} >= VS_START) && ({1'b0, next_line} < VS_STOP)) begin
            next_vsync = VS_POL;
        end
    end

    // ------------------------------------------------- registered raster
    // Reset parks the counters on the last position so the first enabled
    // edge lands on (0,0). A freeze holds position and syncs (no sync glitch
    // during a stall) and clears the per-position flags, so a strobe eaten by
    // the freeze is never repeated for the held position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel     <= H_LAST;
            line      <= V_LAST;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
            de        <= 1'b0;
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
        end else if (enable) begin
            pixel     <= next_pixel;
            line      <= next_line;
            line_end  <= next_line_end;
            frame_end <= next_frame_end;
            de        <= next_de;
            hsync     <= next_hsync;
            vsync     <= next_vsync;
        end else begin
            line_end  <= 1'b0;
            frame_end <= 1'b0;
            de        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// -----------------------------------------------------------------------------
// tb_video_timing
// Drives two video_timing instances in lockstep from one enable/reset:
//   d_* : default 1280x720p60 timing (1650x750 total)
//   s_* : a 16x10 raster (8+2+3+3 by 6+1+2+1, HS_POL=1, VS_POL=0) so that
//         whole frames fit in a short run.
// A small reference model (adv/mreset) tracks both rasters from the spec
// formulas; directed checks use hand-computed constants.
// -----------------------------------------------------------------------------
module tb_video_timing;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;

    logic [11:0] d_pixel, d_line, s_pixel, s_line;
    logic d_line_end, d_frame_end, d_halt, d_de, d_hsync, d_vsync;
    logic s_line_end, s_frame_end, s_halt, s_de, s_hsync, s_vsync;

    int total = 0;
    int bad = 0;

    typedef struct {
        int ha; int hf; int hsw; int hb;
        int va; int vf; int vsw; int vb;
        bit hpol; bit vpol;
    } cfg_t;

    typedef struct {
        int p; int l;
        bit le; bit fe; bit de; bit hs; bit vs; bit halt;
    } mstate_t;

    cfg_t dcfg = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
    cfg_t scfg = '{8, 2, 3, 3, 6, 1, 2, 1, 1'b1, 1'b0};
    mstate_t dm;
    mstate_t sm;

    // ------------------------------------------------------- clock / DUTs
    always #5 clk = ~clk;

    video_timing u_dut_default (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pixel(d_pixel), .line(d_line), .line_end(d_line_end),
        .frame_end(d_frame_end), .halt(d_halt), .de(d_de),
        .hsync(d_hsync), .vsync(d_vsync)
    );

    video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_dut_small (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pixel(s_pixel), .line(s_line), .line_end(s_line_end),
        .frame_end(s_frame_end), .halt(s_halt), .de(s_de),
        .hsync(s_hsync), .vsync(s_vsync)
    );

    // ------------------------------------------------------- model
    function automatic mstate_t mreset(cfg_t c);
        mstate_t m;
        m.p = c.ha + c.hf + c.hsw + c.hb - 1;
        m.l = c.va + c.vf + c.vsw + c.vb - 1;
        m.le = 1'b0; m.fe = 1'b0; m.de = 1'b0; m.halt = 1'b1;
        m.hs = !c.hpol; m.vs = !c.vpol;
        return m;
    endfunction

    function automatic mstate_t adv(mstate_t m, cfg_t c, bit en);
        mstate_t n = m;
        int ht = c.ha + c.hf + c.hsw + c.hb;
        int vt = c.va + c.vf + c.vsw + c.vb;
        if (en) begin
            if (m.p == ht - 1) begin
                n.p = 0;
                n.l = (m.l == vt - 1) ? 0 : m.l + 1;
            end else begin
                n.p = m.p + 1;
            end
            n.halt = 1'b0;
            n.le = (n.p == ht - 1);
            n.fe = n.le && (n.l == vt - 1);
            n.de = (n.p < c.ha) && (n.l < c.va);
            n.hs = (n.p >= c.ha + c.hf && n.p < c.ha + c.hf + c.hsw) ? c.hpol : !c.hpol;
            n.vs = (n.l >= c.va + c.vf && n.l < c.va + c.vf + c.vsw) ? c.vpol : !c.vpol;
        end else begin
            n.halt = 1'b1; n.le = 1'b0; n.fe = 1'b0; n.de = 1'b0;
        end
        return n;
    endfunction

    // ------------------------------------------------------- drivers
    // Called at a negedge; returns at the following negedge (sample point).
    task automatic cycle(input bit en);
        enable = en;
        @(posedge clk);
        sm = adv(sm, scfg, en);
        dm = adv(dm, dcfg, en);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        sm = mreset(scfg);
        dm = mreset(dcfg);
        rst_n = 1'b1;
    endtask

    task automatic run_to_s(input int p, input int l);
        int guard = 0;
        while (!(sm.p == p && sm.l == l) && guard < 400) begin
            cycle(1'b1);
            guard++;
        end
        total++;
        if (s_pixel !== 12'(p) || s_line !== 12'(l)) begin
            bad++;
            $display("FAIL run_to_s got=(%0d,%0d) want=(%0d,%0d)", s_pixel, s_line, p, l);
        end
    endtask

    task automatic run_to_d(input int p, input int l);
        int guard = 0;
        while (!(dm.p == p && dm.l == l) && guard < 30000) begin
            cycle(1'b1);
            guard++;
        end
        total++;
        if (d_pixel !== 12'(p) || d_line !== 12'(l)) begin
            bad++;
            $display("FAIL run_to_d got=(%0d,%0d) want=(%0d,%0d)", d_pixel, d_line, p, l);
        end
    endtask

    // ------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (d_pixel !== 12'd1649 || d_line !== 12'd749) begin
            bad++; $display("FAIL reset_d_pos got=(%0d,%0d) want=(1649,749)", d_pixel, d_line);
        end
        total++;
        if ({d_line_end, d_frame_end, d_de, d_halt, d_hsync, d_vsync} !== 6'b000100) begin
            bad++; $display("FAIL reset_d_flags got=%b want=000100",
                {d_line_end, d_frame_end, d_de, d_halt, d_hsync, d_vsync});
        end
        total++;
        if (s_pixel !== 12'd15 || s_line !== 12'd9) begin
            bad++; $display("FAIL reset_s_pos got=(%0d,%0d) want=(15,9)", s_pixel, s_line);
        end
        total++;
        if ({s_line_end, s_frame_end, s_de, s_halt, s_hsync, s_vsync} !== 6'b000101) begin
            bad++; $display("FAIL reset_s_flags got=%b want=000101",
                {s_line_end, s_frame_end, s_de, s_halt, s_hsync, s_vsync});
        end
    endtask

    task automatic test_first_edge();
        apply_reset();
        cycle(1'b1);
        total++;
        if (d_pixel !== 12'd0 || d_line !== 12'd0) begin
            bad++; $display("FAIL first_d_pos got=(%0d,%0d) want=(0,0)", d_pixel, d_line);
        end
        total++;
        if ({d_de, d_halt, d_line_end, d_frame_end} !== 4'b1000) begin
            bad++; $display("FAIL first_d_flags got=%b want=1000", {d_de, d_halt, d_line_end, d_frame_end});
        end
        total++;
        if (s_pixel !== 12'd0 || s_line !== 12'd0 || s_de !== 1'b1 || s_halt !== 1'b0) begin
            bad++; $display("FAIL first_s got=(%0d,%0d,de%b,halt%b) want=(0,0,de1,halt0)",
                s_pixel, s_line, s_de, s_halt);
        end
    endtask

    // One full default-timing line following the first edge.
    task automatic test_default_line();
        int le_cnt = 0;
        int hs_cnt = 0;
        int de_cnt = 0;
        for (int i = 1; i < 1650; i++) begin
            cycle(1'b1);
            total++;
            if (d_pixel !== 12'(i) || d_line !== 12'd0 || d_halt !== 1'b0) begin
                bad++; $display("FAIL line_pos i=%0d got=(%0d,%0d,halt%b)", i, d_pixel, d_line, d_halt);
            end
            total++;
            if (d_line_end !== (i == 1649) || d_frame_end !== 1'b0) begin
                bad++; $display("FAIL line_strobe i=%0d got=le%b fe%b want=le%b fe0",
                    i, d_line_end, d_frame_end, (i == 1649));
            end
            total++;
            if (d_de !== (i < 1280)) begin
                bad++; $display("FAIL line_de i=%0d got=%b want=%b", i, d_de, (i < 1280));
            end
            total++;
            if (d_hsync !== (i >= 1390 && i < 1430)) begin
                bad++; $display("FAIL line_hsync i=%0d got=%b want=%b", i, d_hsync, (i >= 1390 && i < 1430));
            end
            if (d_line_end === 1'b1) le_cnt++;
            if (d_hsync === 1'b1) hs_cnt++;
            if (d_de === 1'b1) de_cnt++;
        end
        total++;
        if (le_cnt != 1 || hs_cnt != 40 || de_cnt != 1279) begin
            bad++; $display("FAIL line_counts got=le%0d hs%0d de%0d want=le1 hs40 de1279",
                le_cnt, hs_cnt, de_cnt);
        end
        cycle(1'b1);
        total++;
        if (d_pixel !== 12'd0 || d_line !== 12'd1 || d_line_end !== 1'b0 || d_de !== 1'b1) begin
            bad++; $display("FAIL line_wrap got=(%0d,%0d,le%b,de%b) want=(0,1,le0,de1)",
                d_pixel, d_line, d_line_end, d_de);
        end
    endtask

    // One full small frame, every output against the model each cycle.
    task automatic test_frame();
        int le_cnt = 0;
        int fe_cnt = 0;
        int vs_cnt = 0;
        int hs_cnt = 0;
        int de_cnt = 0;
        apply_reset();
        for (int i = 0; i < 160; i++) begin
            cycle(1'b1);
            total++;
            if (s_pixel !== 12'(sm.p) || s_line !== 12'(sm.l)) begin
                bad++; $display("FAIL frame_pos i=%0d got=(%0d,%0d) want=(%0d,%0d)",
                    i, s_pixel, s_line, sm.p, sm.l);
            end
            total++;
            if ({s_line_end, s_frame_end, s_de, s_hsync, s_vsync, s_halt} !==
                {sm.le, sm.fe, sm.de, sm.hs, sm.vs, sm.halt}) begin
                bad++; $display("FAIL frame_flags i=%0d got=%b want=%b", i,
                    {s_line_end, s_frame_end, s_de, s_hsync, s_vsync, s_halt},
                    {sm.le, sm.fe, sm.de, sm.hs, sm.vs, sm.halt});
            end
            if (s_frame_end === 1'b1) begin
                total++;
                if (s_line_end !== 1'b1 || s_pixel !== 12'd15 || s_line !== 12'd9) begin
                    bad++; $display("FAIL frame_end_pos got=(%0d,%0d,le%b) want=(15,9,le1)",
                        s_pixel, s_line, s_line_end);
                end
            end
            if (s_line_end === 1'b1) le_cnt++;
            if (s_frame_end === 1'b1) fe_cnt++;
            if (s_vsync === 1'b0) vs_cnt++;
            if (s_hsync === 1'b1) hs_cnt++;
            if (s_de === 1'b1) de_cnt++;
        end
        total++;
        if (le_cnt != 10 || fe_cnt != 1) begin
            bad++; $display("FAIL frame_strobes got=le%0d fe%0d want=le10 fe1", le_cnt, fe_cnt);
        end
        total++;
        if (vs_cnt != 32 || hs_cnt != 30 || de_cnt != 48) begin
            bad++; $display("FAIL frame_regions got=vs%0d hs%0d de%0d want=vs32 hs30 de48",
                vs_cnt, hs_cnt, de_cnt);
        end
        cycle(1'b1);
        total++;
        if (s_pixel !== 12'd0 || s_line !== 12'd0 || s_frame_end !== 1'b0) begin
            bad++; $display("FAIL frame_wrap got=(%0d,%0d,fe%b) want=(0,0,fe0)", s_pixel, s_line, s_frame_end);
        end
    endtask

    // Freeze inside both sync pulses: syncs must hold their active level.
    task automatic test_sync_hold();
        run_to_s(11, 7);
        total++;
        if (s_hsync !== 1'b1 || s_vsync !== 1'b0) begin
            bad++; $display("FAIL hold_pre got=hs%b vs%b want=hs1 vs0", s_hsync, s_vsync);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            total++;
            if (s_hsync !== 1'b1 || s_vsync !== 1'b0 || s_halt !== 1'b1 || s_de !== 1'b0 ||
                s_pixel !== 12'd11 || s_line !== 12'd7) begin
                bad++; $display("FAIL hold_frozen i=%0d got=(%0d,%0d,hs%b,vs%b,halt%b,de%b)",
                    i, s_pixel, s_line, s_hsync, s_vsync, s_halt, s_de);
            end
        end
        cycle(1'b1);
        total++;
        if (s_pixel !== 12'd12 || s_hsync !== 1'b1 || s_halt !== 1'b0) begin
            bad++; $display("FAIL hold_resume got=(%0d,hs%b,halt%b) want=(12,hs1,halt0)", s_pixel, s_hsync, s_halt);
        end
        cycle(1'b1);
        total++;
        if (s_pixel !== 12'd13 || s_hsync !== 1'b0) begin
            bad++; $display("FAIL hold_sync_end got=(%0d,hs%b) want=(13,hs0)", s_pixel, s_hsync);
        end
    endtask

    // Freeze on the last pixel of line 10 (default timing).
    task automatic test_freeze();
        int le_cnt = 0;
        apply_reset();
        run_to_d(1649, 10);
        total++;
        if (d_line_end !== 1'b1 || d_halt !== 1'b0) begin
            bad++; $display("FAIL freeze_pre got=le%b halt%b want=le1 halt0", d_line_end, d_halt);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            total++;
            if (d_halt !== 1'b1 || d_line_end !== 1'b0 || d_de !== 1'b0) begin
                bad++; $display("FAIL freeze_flags i=%0d got=halt%b le%b de%b want=halt1 le0 de0",
                    i, d_halt, d_line_end, d_de);
            end
            total++;
            if (d_pixel !== 12'd1649 || d_line !== 12'd10 || d_hsync !== 1'b0 || d_vsync !== 1'b0) begin
                bad++; $display("FAIL freeze_hold i=%0d got=(%0d,%0d,hs%b,vs%b) want=(1649,10,hs0,vs0)",
                    i, d_pixel, d_line, d_hsync, d_vsync);
            end
            if (d_line_end === 1'b1) le_cnt++;
        end
        cycle(1'b1);
        if (d_line_end === 1'b1) le_cnt++;
        total++;
        if (d_pixel !== 12'd0 || d_line !== 12'd11 || d_halt !== 1'b0 || d_de !== 1'b1) begin
            bad++; $display("FAIL freeze_resume got=(%0d,%0d,halt%b,de%b) want=(0,11,halt0,de1)",
                d_pixel, d_line, d_halt, d_de);
        end
        total++;
        if (le_cnt != 0) begin
            bad++; $display("FAIL freeze_no_restrobe got=%0d want=0", le_cnt);
        end
    endtask

    // enable alternating 1/0 for two small frames.
    task automatic test_toggle();
        int vis[160];
        int fe_cnt = 0;
        int bad_vis = 0;
        int idx;
        foreach (vis[k]) vis[k] = 0;
        apply_reset();
        for (int i = 0; i < 320; i++) begin
            cycle(1'b1);
            total++;
            if (s_halt !== 1'b0 || s_pixel !== 12'(sm.p) || s_line !== 12'(sm.l) ||
                s_de !== sm.de || s_frame_end !== sm.fe || s_line_end !== sm.le) begin
                bad++; $display("FAIL toggle_run i=%0d got=(%0d,%0d,halt%b,de%b,fe%b,le%b) want=(%0d,%0d,0,%b,%b,%b)",
                    i, s_pixel, s_line, s_halt, s_de, s_frame_end, s_line_end, sm.p, sm.l, sm.de, sm.fe, sm.le);
            end
            if (s_frame_end === 1'b1) fe_cnt++;
            idx = int'(s_line) * 16 + int'(s_pixel);
            if (s_halt === 1'b0 && s_pixel < 12'd16 && s_line < 12'd10) vis[idx]++;
            cycle(1'b0);
            total++;
            if (s_halt !== 1'b1 || s_line_end !== 1'b0 || s_frame_end !== 1'b0 || s_de !== 1'b0 ||
                s_pixel !== 12'(sm.p) || s_line !== 12'(sm.l)) begin
                bad++; $display("FAIL toggle_frozen i=%0d got=(%0d,%0d,halt%b,le%b,fe%b,de%b) want=(%0d,%0d,1,0,0,0)",
                    i, s_pixel, s_line, s_halt, s_line_end, s_frame_end, s_de, sm.p, sm.l);
            end
        end
        foreach (vis[k]) if (vis[k] != 2) bad_vis++;
        total++;
        if (fe_cnt != 2) begin
            bad++; $display("FAIL toggle_frame_end got=%0d want=2", fe_cnt);
        end
        total++;
        if (bad_vis != 0) begin
            bad++; $display("FAIL toggle_visits positions_not_twice got=%0d want=0", bad_vis);
        end
    endtask

    // Asynchronous reset in the middle of active video.
    task automatic test_async_reset();
        run_to_s(5, 3);
        total++;
        if (s_de !== 1'b1 || s_halt !== 1'b0) begin
            bad++; $display("FAIL async_pre got=de%b halt%b want=de1 halt0", s_de, s_halt);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (s_pixel !== 12'd15 || s_line !== 12'd9 ||
            {s_line_end, s_frame_end, s_de, s_halt, s_hsync, s_vsync} !== 6'b000101) begin
            bad++; $display("FAIL async_s got=(%0d,%0d,%b) want=(15,9,000101)", s_pixel, s_line,
                {s_line_end, s_frame_end, s_de, s_halt, s_hsync, s_vsync});
        end
        total++;
        if (d_pixel !== 12'd1649 || d_line !== 12'd749 ||
            {d_line_end, d_frame_end, d_de, d_halt, d_hsync, d_vsync} !== 6'b000100) begin
            bad++; $display("FAIL async_d got=(%0d,%0d,%b) want=(1649,749,000100)", d_pixel, d_line,
                {d_line_end, d_frame_end, d_de, d_halt, d_hsync, d_vsync});
        end
        @(negedge clk);
        sm = mreset(scfg);
        dm = mreset(dcfg);
        rst_n = 1'b1;
        cycle(1'b1);
        total++;
        if (s_pixel !== 12'd0 || s_line !== 12'd0 || d_pixel !== 12'd0 || d_line !== 12'd0 ||
            s_de !== 1'b1 || d_halt !== 1'b0) begin
            bad++; $display("FAIL async_restart got=s(%0d,%0d) d(%0d,%0d) de%b halt%b want=(0,0) de1 halt0",
                s_pixel, s_line, d_pixel, d_line, s_de, d_halt);
        end
    endtask

    // ------------------------------------------------------- sequence
    initial begin
        sm = mreset(scfg);
        dm = mreset(dcfg);
        @(negedge clk);
        test_reset();
        test_first_edge();
        test_default_line();
        test_frame();
        test_sync_hold();
        test_freeze();
        test_toggle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
